// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - shifts host bitstream words serially onto the configuration-chain head
// Optional CRC-16 readback of ccff_tail is compiled in with CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 4,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic              busy,
  output logic              done,
  output logic              config_done,
  output logic [15:0]       rb_crc
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
  localparam int BL_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              config_done_q, config_done_d;
  logic              accept;

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    bits_left_d   = bits_left_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    head_d        = head_q;
    en_d          = 1'b0;
    done_d        = 1'b0;
    config_done_d = config_done_q;
    s_ready       = (state_q == LOAD) && (word_cnt_q < WC_W'(NUM_WORDS))
                    && (bits_left_q <= BL_W'(1));
    accept        = s_valid && s_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = LOAD;
          buf_d         = '0;
          bits_left_d   = '0;
          bit_cnt_d     = '0;
          word_cnt_d    = '0;
          config_done_d = 1'b0;
        end
      end
      LOAD: begin
        if (bits_left_q != '0) begin
          head_d      = buf_q[WORD_W-1];
          en_d        = 1'b1;
          buf_d       = buf_q << 1;
          bits_left_d = bits_left_q - BL_W'(1);
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) state_d = FIN;
        end
        // A new word may land on the same edge that emits the previous word's last bit.
        if (accept) begin
          buf_d       = s_data;
          bits_left_d = (word_cnt_q == WC_W'(NUM_WORDS - 1)) ? BL_W'(LAST_BITS) : BL_W'(WORD_W);
          word_cnt_d  = word_cnt_q + WC_W'(1);
        end
      end
      FIN: begin
        done_d        = 1'b1;
        config_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      bits_left_q   <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      head_q        <= 1'b0;
      en_q          <= 1'b0;
      done_q        <= 1'b0;
      config_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      bits_left_q   <= bits_left_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      head_q        <= head_d;
      en_q          <= en_d;
      done_q        <= done_d;
      config_done_q <= config_done_d;
    end
  end

  assign ccff_head   = head_q;
  assign cfg_clk_en  = en_q;
  assign busy        = (state_q == LOAD);
  assign done        = done_q;
  assign config_done = config_done_q;

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;

  // The tail is sampled on the same edge the chain shifts, so it still holds the old contents.
  always_comb begin
    crc_d  = crc_q;
    crc_fb = crc_q[15] ^ ccff_tail;
    if ((state_q == IDLE) && start) begin
      crc_d = 16'hFFFF;
    end else if (en_q) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign rb_crc = crc_q;
`else
  logic tail_unused;
  assign tail_unused = ccff_tail;
  assign rb_crc      = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed and randomized checks of ccff_chain_loader
// Two instances (8-bit and 10-bit chains) share clock and reset; sel routes stimulus.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, s_valid = 1'b0, sel = 1'b0;
  logic [3:0] s_data = 4'h0;
  logic       st8, sv8, st10, sv10;
  logic       ready8, head8, en8, busy8, done8, cdone8, tail8;
  logic       ready10, head10, en10, busy10, done10, cdone10, tail10;
  logic [15:0] crc8, crc10;

  assign st8  = start & ~sel;
  assign sv8  = s_valid & ~sel;
  assign st10 = start & sel;
  assign sv10 = s_valid & sel;

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(4)) dut8 (
    .prog_clk(clk), .pReset(rst), .start(st8), .s_data(s_data), .s_valid(sv8),
    .s_ready(ready8), .ccff_head(head8), .ccff_tail(tail8), .cfg_clk_en(en8),
    .busy(busy8), .done(done8), .config_done(cdone8), .rb_crc(crc8));

  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) dut10 (
    .prog_clk(clk), .pReset(rst), .start(st10), .s_data(s_data), .s_valid(sv10),
    .s_ready(ready10), .ccff_head(head10), .ccff_tail(tail10), .cfg_clk_en(en10),
    .busy(busy10), .done(done10), .config_done(cdone10), .rb_crc(crc10));

  logic        r_sel, h_sel, e_sel, b_sel, d_sel, c_sel;
  logic [15:0] crc_sel;
  assign r_sel   = sel ? ready10 : ready8;
  assign h_sel   = sel ? head10  : head8;
  assign e_sel   = sel ? en10    : en8;
  assign b_sel   = sel ? busy10  : busy8;
  assign d_sel   = sel ? done10  : done8;
  assign c_sel   = sel ? cdone10 : cdone8;
  assign crc_sel = sel ? crc10   : crc8;

  // Behavioural model of the downstream chains: shift on enabled edges, first bit ends farthest.
  logic [7:0] chain8  = 8'h00;
  logic [9:0] chain10 = 10'h000;
  int         cyc = 0;
  assign tail8  = chain8[7];
  assign tail10 = chain10[9];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en8)  chain8  <= {chain8[6:0], head8};
    if (en10) chain10 <= {chain10[8:0], head10};
  end

  bit bitq[$];
  int en_cnt = 0, done_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (e_sel) begin
        bitq.push_back(h_sel);
        en_cnt = en_cnt + 1;
      end
      if (d_sel) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [15:0] ch, input int len);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = len - 1; i >= 0; i--) begin
      fb = c[15] ^ ch[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [3:0] wv [4];
  int         gv [4];

  // gv[i]: idle edges after the previous accept (or after start) before s_valid rises.
  task automatic do_load(input int nw, input bit restart, input string tag);
    int          len, n, a, rdy, base, st, b0, d0, e0, k;
    bit          acc;
    logic [15:0] old_chain, exp_crc;
    logic [31:0] obs_bits, exp_bits;
    len = sel ? 10 : 8;
    old_chain = sel ? 16'(chain10) : 16'(chain8);
    b0 = bitq.size(); d0 = done_cnt; e0 = en_cnt;
    exp_bits = 0;
    for (int i = 0; i < len; i++) exp_bits = {exp_bits[30:0], wv[i / 4][3 - (i % 4)]};
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    st = cyc;
    check({tag, "_busy"}, 32'(b_sel), 32'd1);
    base = st; rdy = st + 1; n = 4;
    for (int i = 0; i < nw; i++) begin
      n = (i == nw - 1) ? len - (nw - 1) * 4 : 4;
      k = 0;
      if (restart && i == 1) begin
        start = 1'b1; @(posedge clk); #1; start = 1'b0; k = 1;
      end
      for (; k < gv[i]; k++) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = wv[i];
      acc = 1'b0;
      for (int t = 0; t < 60 && !acc; t++) begin
        acc = r_sel;
        @(posedge clk); #1;
      end
      s_valid = 1'b0;
      a = (rdy > base + gv[i] + 1) ? rdy : base + gv[i] + 1;
      check({tag, "_accepted"}, 32'(acc), 32'd1);
      check({tag, "_accept_edge"}, cyc - st, a - st);
      base = a; rdy = a + n;
    end
    check({tag, "_ready_after_last"}, 32'(r_sel), 32'd0);
    for (int t = 0; t < 100 && done_cnt == d0; t++) @(negedge clk);
    check({tag, "_done_latency"}, done_cyc - st, rdy + 1 - st);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - d0, 32'd1);
    check({tag, "_en_cycles"}, en_cnt - e0, len);
    obs_bits = 0;
    for (int i = 0; i < len; i++) obs_bits = {obs_bits[30:0], (b0 + i < bitq.size()) ? bitq[b0 + i] : 1'bx};
    check({tag, "_bits"}, obs_bits, exp_bits);
    check({tag, "_chain"}, sel ? 32'(chain10) : 32'(chain8), exp_bits);
    check({tag, "_config_done"}, 32'(c_sel), 32'd1);
    check({tag, "_idle"}, 32'(b_sel), 32'd0);
`ifdef CCFF_READBACK_EN
    exp_crc = crc_of(old_chain, len);
`else
    exp_crc = 16'h0000;
`endif
    check({tag, "_rb_crc"}, 32'(crc_sel), 32'(exp_crc));
  endtask

  initial begin
    int e0;
    #1;
    check("reset_outputs", {ready8, head8, en8, busy8, done8, cdone8, crc8,
                            ready10, head10, en10, busy10, done10, cdone10, crc10}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Back-to-back words 0xA, 0x5 into an all-zero chain.
    sel = 1'b0; wv[0] = 4'hA; wv[1] = 4'h5; gv[0] = 0; gv[1] = 0;
    do_load(2, 1'b0, "a5_stream");
`ifdef CCFF_READBACK_EN
    check("a5_crc_of_zeros", 32'(crc8), 32'hE1F0);
`else
    check("a5_crc_tied", 32'(crc8), 32'h0);
`endif

    // Second word delayed so the stream stalls three cycles (done at 13).
    gv[1] = 6;
    do_load(2, 1'b0, "a5_gap");

    // 10-bit chain: three words, last word contributes only its top two bits.
    sel = 1'b1; wv[0] = 4'hF; wv[1] = 4'h0; wv[2] = 4'hB; gv[0] = 0; gv[1] = 0; gv[2] = 0;
    do_load(3, 1'b0, "len10");

    // start pulsed mid-load must not restart the count.
    sel = 1'b0; wv[0] = 4'h3; wv[1] = 4'h9; gv[0] = 1; gv[1] = 2;
    do_load(2, 1'b1, "restart_ignored");

    // Reset after three bits, then a clean reload of 0xC3.
    e0 = en_cnt;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; s_valid = 1'b1; s_data = 4'hC;
    for (int t = 0; t < 50 && (en_cnt - e0) < 3; t++) @(negedge clk);
    check("pre_reset_bits", en_cnt - e0, 32'd3);
    #2; rst = 1'b1; #1;
    check("async_reset_outputs", {ready8, head8, en8, busy8, done8, cdone8, crc8}, 32'd0);
    s_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    wv[0] = 4'hC; wv[1] = 4'h3; gv[0] = 0; gv[1] = 0;
    do_load(2, 1'b0, "c3_after_reset");

    for (int r = 0; r < 6; r++) begin
      sel = r[0];
      for (int i = 0; i < 4; i++) begin
        wv[i] = 4'($urandom_range(0, 15));
        gv[i] = $urandom_range(0, 6);
      end
      if (r == 2 && gv[1] == 0) gv[1] = 1;
      do_load(sel ? 3 : 2, r == 2, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
